// File: rtl/tt_alu_seq.sv
// Handshaked W-bit ALU with accumulator and shift-add multiplier.
// Optional ALU_SAT_EN: saturating ADD/SUB/ACC.
module tt_alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         cout,
  output logic         zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ACC = 3'd5;
  localparam logic [2:0] OP_CLR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int CW = $clog2(W);

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [W-1:0]  mcand;
  logic [W-1:0]  p_hi;
  logic [W-1:0]  p_lo;
  logic [CW-1:0] cnt;

  logic [W:0]    sum;
  logic [W:0]    dif;
  logic [W:0]    asum;
  logic [W-1:0]  c_res;
  logic          c_cout;
  logic [W-1:0]  c_acc;
  logic          c_acc_we;

  logic [W:0]    step;
  logic [W-1:0]  n_hi;
  logic [W-1:0]  n_lo;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign asum = {1'b0, acc} + {1'b0, a};

  always_comb begin
    c_res    = '0;
    c_cout   = 1'b0;
    c_acc    = acc;
    c_acc_we = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        c_res  = sum[W-1:0];
        c_cout = sum[W];
`ifdef ALU_SAT_EN
        if (sum[W]) c_res = '1;
`endif
      end
      (op == OP_SUB): begin
        c_res  = dif[W-1:0];
        c_cout = dif[W];
`ifdef ALU_SAT_EN
        if (dif[W]) c_res = '0;
`endif
      end
      (op == OP_AND): c_res = a & b;
      (op == OP_OR):  c_res = a | b;
      (op == OP_XOR): c_res = a ^ b;
      (op == OP_ACC): begin
        c_res  = asum[W-1:0];
        c_cout = asum[W];
`ifdef ALU_SAT_EN
        if (asum[W]) c_res = '1;
`endif
        c_acc    = c_res;
        c_acc_we = 1'b1;
      end
      (op == OP_CLR): begin
        c_acc    = '0;
        c_acc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // One shift-add step: add multiplicand on LSB, shift {hi,lo} right.
  assign step = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign n_hi = step[W:1];
  assign n_lo = {step[0], p_lo[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand <= a;
              p_hi  <= '0;
              p_lo  <= b;
              cnt   <= '0;
              state <= S_BUSY;
            end else begin
              result    <= c_res;
              result_hi <= '0;
              cout      <= c_cout;
              zero      <= (c_res == '0);
              if (c_acc_we) acc <= c_acc;
              state     <= S_HOLD;
            end
          end
        end
        S_BUSY: begin
          p_hi <= n_hi;
          p_lo <= n_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            result    <= n_lo;
            result_hi <= n_hi;
            cout      <= |n_hi;
            zero      <= ~|{n_hi, n_lo};
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_alu_seq.sv
// Directed self-checking bench for tt_alu_seq (W=8).
// Expectations follow ALU_SAT_EN when defined.
module tb_tt_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       cout;
  logic       zero;

  int n_tests = 0;
  int n_fail  = 0;
  int edges;

`ifdef ALU_SAT_EN
  localparam int ADD_E = 255;
  localparam int SUB_E = 0;
  localparam int SUB_Z = 1;
  localparam int ACC_E = 255;
`else
  localparam int ADD_E = 44;
  localparam int SUB_E = 254;
  localparam int SUB_Z = 0;
  localparam int ACC_E = 4;
`endif

  tt_alu_seq #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .cout      (cout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y);
    @(negedge clk);
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int e);
    e = 0;
    while (!out_valid && e < maxc) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("xfer_out_valid", 32'(out_valid), 32'd0);
    chk("xfer_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic res(input string tag, input int r, input int h,
                     input int c, input int z);
    chk({tag, "_res"}, 32'(result), 32'(r));
    chk({tag, "_hi"}, 32'(result_hi), 32'(h));
    chk({tag, "_cout"}, 32'(cout), 32'(c));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    res("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 8'd200, 8'd100);
    chk("add_lat", 32'(out_valid), 32'd1);
    res("add", ADD_E, 0, 1, 0);
    take();

    issue(3'd1, 8'd5, 8'd7);
    wait_valid(4, edges);
    res("sub", SUB_E, 0, 1, SUB_Z);
    take();

    issue(3'd2, 8'hF0, 8'h3C);
    wait_valid(4, edges);
    res("and", 'h30, 0, 0, 0);
    take();

    issue(3'd3, 8'h0F, 8'h30);
    wait_valid(4, edges);
    res("or", 'h3F, 0, 0, 0);
    take();

    issue(3'd4, 8'hFF, 8'hFF);
    wait_valid(4, edges);
    res("xor", 0, 0, 0, 1);
    take();

    issue(3'd7, 8'd255, 8'd255);
    chk("mul_busy", 32'(out_valid), 32'd0);
    wait_valid(20, edges);
    chk("mul_lat", 32'(edges), 32'd8);
    res("mul1", 'h01, 'hFE, 1, 0);
    take();

    issue(3'd7, 8'd15, 8'd17);
    wait_valid(20, edges);
    res("mul2", 'hFF, 0, 0, 0);
    take();

    issue(3'd6, 8'd9, 8'd9);
    wait_valid(4, edges);
    res("clr", 0, 0, 0, 1);
    take();
    issue(3'd5, 8'd250, 8'd0);
    wait_valid(4, edges);
    res("acc1", 250, 0, 0, 0);
    take();
    issue(3'd5, 8'd10, 8'd99);
    wait_valid(4, edges);
    res("acc2", ACC_E, 0, 1, 0);
    take();

    issue(3'd0, 8'd3, 8'd4);
    wait_valid(4, edges);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = 3'd1;
      a = 8'd0;
      b = 8'd1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      res("bp", 7, 0, 0, 0);
    end
    in_valid = 1'b0;
    take();

    issue(3'd5, 8'd1, 8'd0);
    wait_valid(4, edges);
    take();
    issue(3'd7, 8'd255, 8'd255);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_acc", 32'(dut.acc), 32'd0);
    res("mrst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 8'd1, 8'd1);
    wait_valid(4, edges);
    res("post_add", 2, 0, 0, 0);
    take();
    issue(3'd5, 8'd5, 8'd0);
    wait_valid(4, edges);
    res("post_acc", 5, 0, 0, 0);
    take();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
